// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered ALU with start/done handshake and iterative shift-add multiply
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   start    request, accepted only when busy=0
//   ALU_op   operation code, sampled with start
//   val_A    operand A, sampled with start
//   val_B    operand B, sampled with start
//   ALU_out  registered result
//   Z, N, V  registered zero / negative / overflow flags
//   busy     high while a multiply is in progress
//   done     one-cycle pulse when ALU_out and flags have just updated

module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       ALU_op,
    input  logic [WIDTH-1:0] val_A,
    input  logic [WIDTH-1:0] val_B,
    output logic [WIDTH-1:0] ALU_out,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOTB = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_LSL  = 3'b101;
    localparam logic [2:0] OP_LSR  = 3'b110;
    localparam logic [2:0] OP_ASR  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;

    logic               accept;
    logic               mul_start;
    logic               mul_last;
    logic               load_en;
    logic [WIDTH-1:0]   res_d;
    logic               v_d;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_v;

    // Single-cycle datapath for every op except MUL.
    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        case (ALU_op)
            OP_ADD: begin
                alu_res = val_A + val_B;
                alu_v   = (val_A[WIDTH-1] == val_B[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != val_A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = val_A - val_B;
                alu_v   = (val_A[WIDTH-1] != val_B[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != val_A[WIDTH-1]);
            end
            OP_AND:  alu_res = val_A & val_B;
            OP_NOTB: alu_res = ~val_B;
            OP_LSL:  alu_res = {val_B[WIDTH-2:0], 1'b0};
            OP_LSR:  alu_res = {1'b0, val_B[WIDTH-1:1]};
            OP_ASR:  alu_res = {val_B[WIDTH-1], val_B[WIDTH-1:1]};
            default: begin
                alu_res = '0;
                alu_v   = 1'b0;
            end
        endcase
    end

    // One shift-add step; on the final step this is the full product.
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start && ALU_op == OP_MUL) state_nxt = ST_MUL;
            ST_MUL:  if (cnt == CNT_W'(1))         state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output / control decode.
    always_comb begin
        busy      = (state == ST_MUL);
        accept    = (state == ST_IDLE) && start;
        mul_start = accept && (ALU_op == OP_MUL);
        mul_last  = (state == ST_MUL) && (cnt == CNT_W'(1));
        load_en   = (accept && !mul_start) || mul_last;
        if (mul_last) begin
            res_d = acc_nxt[WIDTH-1:0];
            v_d   = |acc_nxt[2*WIDTH-1:WIDTH];
        end else begin
            res_d = alu_res;
            v_d   = alu_v;
        end
    end

    // Multiply engine: operands are latched once and ignore the ports
    // until the product is written back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (mul_start) begin
            cnt    <= CNT_W'(WIDTH);
            mcand  <= {{WIDTH{1'b0}}, val_A};
            mplier <= val_B;
            acc    <= '0;
        end else if (state == ST_MUL) begin
            cnt    <= cnt - CNT_W'(1);
            mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
            acc    <= acc_nxt;
        end
    end

    // Result and flag registers hold between loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALU_out <= '0;
            Z       <= 1'b0;
            N       <= 1'b0;
            V       <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= load_en;
            if (load_en) begin
                ALU_out <= res_d;
                Z       <= (res_d == '0);
                N       <= res_d[WIDTH-1];
                V       <= v_d;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu

module tb_seq_alu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  ALU_op;
    logic [15:0] val_A;
    logic [15:0] val_B;
    logic [15:0] ALU_out;
    logic        Z, N, V, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    seq_alu #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ALU_op  (ALU_op),
        .val_A   (val_A),
        .val_B   (val_B),
        .ALU_out (ALU_out),
        .Z       (Z),
        .N       (N),
        .V       (V),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive start for exactly one edge; returns at the negedge after it.
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        start  = 1'b1;
        ALU_op = op;
        val_A  = a;
        val_B  = b;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [15:0] r,
                             input logic z, input logic n, input logic v);
        check_val({tag, "_out"}, 32'(ALU_out), 32'(r));
        check_val({tag, "_z"},   32'(Z),       32'(z));
        check_val({tag, "_n"},   32'(N),       32'(n));
        check_val({tag, "_v"},   32'(V),       32'(v));
    endtask

    // Wait for done with a bound; reports cycles waited and busy-high cycles.
    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc      = 0;
        busy_cyc = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    int cyc, bcyc, dones, first_done;
    logic [15:0] held;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        ALU_op = 3'b000;
        val_A  = '0;
        val_B  = '0;
        repeat (2) @(negedge clk);
        check_res("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ADD overflow, done exactly one cycle
        issue(3'b000, 16'h7FFF, 16'h0001);
        check_val("add_done", 32'(done), 32'd1);
        check_res("add", 16'h8000, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check_val("add_done_clr", 32'(done), 32'd0);

        // SUB cases
        issue(3'b001, 16'd5, 16'd5);
        check_res("sub_eq", 16'h0000, 1'b1, 1'b0, 1'b0);
        issue(3'b001, 16'd1, 16'd2);
        check_res("sub_neg", 16'hFFFF, 1'b0, 1'b1, 1'b0);
        issue(3'b001, 16'h8000, 16'd1);
        check_res("sub_ovf", 16'h7FFF, 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        // MUL 300*200
        issue(3'b100, 16'd300, 16'd200);
        check_val("mul1_done_early", 32'(done), 32'd0);
        check_val("mul1_hold", 32'(ALU_out), 32'h7FFF);
        wait_done(cyc, bcyc);
        check_val("mul1_latency", 32'(cyc), 32'd16);
        check_val("mul1_busy_cycles", 32'(bcyc), 32'd16);
        check_val("mul1_busy_end", 32'(busy), 32'd0);
        check_res("mul1", 16'hEA60, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_val("mul1_done_clr", 32'(done), 32'd0);

        // MUL 0x100*0x100 overflow
        issue(3'b100, 16'h0100, 16'h0100);
        wait_done(cyc, bcyc);
        check_val("mul2_latency", 32'(cyc), 32'd16);
        check_res("mul2", 16'h0000, 1'b1, 1'b0, 1'b1);
        @(negedge clk);

        // Busy lockout: ADD during MUL ignored, operands changed too
        issue(3'b100, 16'd7, 16'd9);
        held       = ALU_out;
        dones      = 0;
        first_done = 0;
        for (int i = 1; i <= 24; i++) begin
            if (i == 3) begin
                start  = 1'b1;
                ALU_op = 3'b000;
                val_A  = 16'd1;
                val_B  = 16'd1;
            end else begin
                start  = 1'b0;
            end
            @(negedge clk);
            if (i == 8) check_val("lock_hold", 32'(ALU_out), 32'(held));
            if (done) begin
                dones++;
                if (first_done == 0) begin
                    first_done = i;
                    check_val("lock_out", 32'(ALU_out), 32'd63);
                end
            end
        end
        check_val("lock_dones", 32'(dones), 32'd1);
        check_val("lock_latency", 32'(first_done), 32'd16);

        // Reset mid-multiply
        issue(3'b100, 16'd123, 16'd45);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_res("rst_mid", 16'h0000, 1'b0, 1'b0, 1'b0);
        check_val("rst_mid_busy", 32'(busy), 32'd0);
        check_val("rst_mid_done", 32'(done), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_val("rst_no_done", 32'(dones), 32'd0);
        issue(3'b010, 16'hF0F0, 16'h0FF0);
        check_res("and", 16'h00F0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Shifts and NOTB back-to-back, issued in done cycles
        issue(3'b111, 16'h1234, 16'h8002);
        check_val("asr_done", 32'(done), 32'd1);
        check_res("asr", 16'hC001, 1'b0, 1'b1, 1'b0);
        issue(3'b110, 16'h1234, 16'h8002);
        check_val("lsr_done", 32'(done), 32'd1);
        check_res("lsr", 16'h4001, 1'b0, 1'b0, 1'b0);
        issue(3'b101, 16'h1234, 16'h8002);
        check_val("lsl_done", 32'(done), 32'd1);
        check_res("lsl", 16'h0004, 1'b0, 1'b0, 1'b0);
        issue(3'b011, 16'h1234, 16'h0000);
        check_val("notb_done", 32'(done), 32'd1);
        check_res("notb", 16'hFFFF, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_val("b2b_done_clr", 32'(done), 32'd0);
        check_val("b2b_hold", 32'(ALU_out), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
